// File: rtl/specialist_pkg.sv
// Shared constants for the Specialist memory map: MX I/O window bases,
// the page that maps the monitor ROM, and the palette value after reset.
package specialist_pkg;

   localparam logic [15:0] BASE_WIN = 16'hFFC0;  // 32-byte RAM-through window
   localparam logic [15:0] PPI1_WIN = 16'hFFE0;
   localparam logic [15:0] PPI2_WIN = 16'hFFE4;
   localparam logic [15:0] FDD_WIN  = 16'hFFE8;
   localparam logic [15:0] PIT_WIN  = 16'hFFEC;
   localparam logic [15:0] FDD2_WIN = 16'hFFF0;
   localparam logic [15:0] RSVD_WIN = 16'hFFF4;  // decodes to nothing
   localparam logic [15:0] PAL_WIN  = 16'hFFF8;
   localparam logic [15:0] PAGE_WIN = 16'hFFFC;

   localparam int          PAGE_ROM      = 1;
   localparam logic [7:0]  PALETTE_RESET = 8'hF0;

   // True when addr falls inside the 4-byte I/O window starting at base.
   function automatic logic in_win4(input logic [15:0] a, input logic [15:0] base);
      return a[15:2] == base[15:2];
   endfunction

endpackage

// File: rtl/fdd_hold_ctrl.sv
// Floppy companion register block: CPU hold handshake with a stuck-hold
// watchdog, plus the head-side and drive-select registers.
module fdd_hold_ctrl #(
   parameter  int NDRIVES  = 2,
   parameter  int HOLD_TMO = 65535,
   localparam int DRV_BITS = (NDRIVES > 1) ? $clog2(NDRIVES) : 1
) (
   input  logic                clk_sys,
   input  logic                reset,
   input  logic                wr_ev,
   input  logic [1:0]          reg_sel,
   input  logic [DRV_BITS-1:0] wr_data,
   input  logic                fdd_drq,
   input  logic                fdd_busy,
   output logic                cpu_hold,
   output logic                hold_timeout,
   output logic                fdd_side,
   output logic [DRV_BITS-1:0] fdd_drive
);

   localparam int                   CNT_W    = $clog2(HOLD_TMO + 1);
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(HOLD_TMO - 1);
   localparam logic [DRV_BITS-1:0]  DRV_MAX  = DRV_BITS'(NDRIVES - 1);

   logic [CNT_W-1:0] hold_cnt;
   logic             hold_set;
   logic             hold_rel;
   logic             tmo_fire;

   // The controller releases the CPU as soon as it wants data or goes idle;
   // the watchdog fires only if that release never arrives.
   assign hold_set = wr_ev && (reg_sel == 2'd0);
   assign hold_rel = fdd_drq | ~fdd_busy;
   assign tmo_fire = cpu_hold && !hold_rel && (hold_cnt == CNT_LAST);

   // Hold flag, timeout flag, watchdog counter and side/drive registers.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         cpu_hold     <= 1'b0;
         hold_timeout <= 1'b0;
         hold_cnt     <= '0;
         fdd_side     <= 1'b0;
         fdd_drive    <= '0;
      end else begin
         if (hold_rel || tmo_fire)
            cpu_hold <= 1'b0;
         else if (hold_set)
            cpu_hold <= 1'b1;

         if (tmo_fire)
            hold_timeout <= 1'b1;
         else if (hold_set)
            hold_timeout <= 1'b0;

         hold_cnt <= cpu_hold ? hold_cnt + CNT_W'(1) : '0;

         if (wr_ev && reg_sel == 2'd2)
            fdd_side <= wr_data[0];
         if (wr_ev && reg_sel == 2'd3)
            fdd_drive <= (wr_data > DRV_MAX) ? DRV_MAX : wr_data;
      end
   end

endmodule

// File: rtl/specialist_mmu.sv
// Specialist / Specialist-MX memory manager: address decode, RAM paging,
// MX palette register, floppy hold control and per-drive image-ready bits.
module specialist_mmu
   import specialist_pkg::*;
#(
   parameter  int PAGE_BITS = 4,
   parameter  int NDRIVES   = 2,
   parameter  int HOLD_TMO  = 65535,
   parameter  int ADDR_W    = 25,
   localparam int DRV_BITS  = (NDRIVES > 1) ? $clog2(NDRIVES) : 1
) (
   input  logic                 clk_sys,
   input  logic                 reset,
   input  logic                 mx,
   input  logic                 mxd,
   input  logic [7:0]           mon,
   input  logic                 rks_load,
   input  logic [15:0]          addr,
   input  logic                 cpu_wr_n,
   input  logic [7:0]           cpu_dout,
   input  logic                 fdd_drq,
   input  logic                 fdd_busy,
   input  logic                 img_mounted,
   input  logic [DRV_BITS-1:0]  img_drive,
   output logic [ADDR_W-1:0]    ram_addr,
   output logic                 rom_sel,
   output logic                 base_sel,
   output logic                 ppi1_sel,
   output logic                 ppi2_sel,
   output logic                 fdd_sel,
   output logic                 pit_sel,
   output logic                 pal_sel,
   output logic                 page_sel,
   output logic                 fdd2_sel,
   output logic [PAGE_BITS-1:0] page,
   output logic [7:0]           color_mx,
   output logic                 fdd_side,
   output logic [DRV_BITS-1:0]  fdd_drive,
   output logic                 fdd_ready,
   output logic                 cpu_hold,
   output logic                 hold_timeout
);

   localparam logic [PAGE_BITS-1:0] PAGE_ROM_V = PAGE_BITS'(PAGE_ROM);

   logic                 romp;
   logic                 wr_n_q;
   logic                 wr_ev;
   logic                 page_clr;
   logic [PAGE_BITS:0]   page_inc;
   logic [PAGE_BITS-1:0] page_sat;

   // Ready bits survive reset on purpose: a mounted image stays mounted.
   logic [NDRIVES-1:0]   drv_ready = '0;
   logic                 img_q     = 1'b0;

   assign romp     = (page == PAGE_ROM_V);
   assign wr_ev    = wr_n_q & ~cpu_wr_n;
   assign page_clr = !(mx && mxd) && addr[15];
   assign page_inc = {1'b0, cpu_dout[PAGE_BITS-1:0]} + (PAGE_BITS+1)'(2);
   assign page_sat = page_inc[PAGE_BITS] ? {PAGE_BITS{1'b1}} : page_inc[PAGE_BITS-1:0];

   // Priority address decode; at most one select is ever high.
   always_comb begin
      rom_sel  = 1'b0;
      base_sel = 1'b0;
      ppi1_sel = 1'b0;
      ppi2_sel = 1'b0;
      fdd_sel  = 1'b0;
      pit_sel  = 1'b0;
      pal_sel  = 1'b0;
      page_sel = 1'b0;
      fdd2_sel = 1'b0;
      if (mx) begin
         if (mxd && romp && addr <= 16'hBFFF)          rom_sel  = 1'b1;
         else if (!mxd && romp && addr[15:12] == 4'h0) rom_sel  = 1'b1;
         else if (!mxd && addr[15:12] == 4'hC)         rom_sel  = 1'b1;
         else if (addr[15:5] == BASE_WIN[15:5])        base_sel = 1'b1;
         else if (in_win4(addr, PPI1_WIN))             ppi1_sel = 1'b1;
         else if (in_win4(addr, PPI2_WIN))             ppi2_sel = 1'b1;
         else if (in_win4(addr, FDD_WIN))              fdd_sel  = 1'b1;
         else if (in_win4(addr, PIT_WIN))              pit_sel  = 1'b1;
         else if (in_win4(addr, FDD2_WIN))             fdd2_sel = 1'b1;
         else if (in_win4(addr, RSVD_WIN))             begin end
         else if (in_win4(addr, PAL_WIN))              pal_sel  = 1'b1;
         else if (in_win4(addr, PAGE_WIN))             page_sel = 1'b1;
         else                                          base_sel = romp;
      end else begin
         if (romp && addr[15:12] == 4'h0)    rom_sel  = 1'b1;
         else if (addr[15:12] == 4'hC)       rom_sel  = 1'b1;
         else if (addr[15:11] == 5'b11110)   ppi2_sel = 1'b1;
         else if (addr[15:11] == 5'b11111)   ppi1_sel = 1'b1;
         else                                base_sel = romp;
      end
   end

   // RAM address: monitor ROM banking in plain mode, page banking with disk.
   always_comb begin
      if (!mxd)
         ram_addr = rom_sel ? ADDR_W'({mon, addr[11:0]}) : ADDR_W'(addr);
      else
         ram_addr = base_sel ? ADDR_W'(addr) : ADDR_W'({page, addr});
   end

   // Write-strobe history so a held-low strobe yields one event.
   always_ff @(posedge clk_sys) begin
      if (reset) wr_n_q <= 1'b1;
      else       wr_n_q <= cpu_wr_n;
   end

   // Page register: high-half access outside MX-disk mode drops back to page 0.
   always_ff @(posedge clk_sys) begin
      if (reset)
         page <= PAGE_ROM_V;
      else if (rks_load || page_clr)
         page <= '0;
      else if (wr_ev && page_sel && mxd) begin
         case (addr[1:0])
            2'd0:    page <= '0;
            2'd1:    page <= page_sat;
            default: page <= PAGE_ROM_V;
         endcase
      end
   end

   // MX palette register.
   always_ff @(posedge clk_sys) begin
      if (reset || rks_load)     color_mx <= PALETTE_RESET;
      else if (wr_ev && pal_sel) color_mx <= cpu_dout;
   end

   // Image-mount edge detection and sticky per-drive ready bits.
   always_ff @(posedge clk_sys) begin
      img_q <= img_mounted;
      if (img_mounted && !img_q) begin
         for (int i = 0; i < NDRIVES; i++)
            if (img_drive == DRV_BITS'(i)) drv_ready[i] <= 1'b1;
      end
   end

   // Ready status of whichever drive is currently selected.
   always_comb begin
      fdd_ready = 1'b0;
      for (int i = 0; i < NDRIVES; i++)
         if (fdd_drive == DRV_BITS'(i)) fdd_ready = drv_ready[i];
   end

   fdd_hold_ctrl #(
      .NDRIVES  (NDRIVES),
      .HOLD_TMO (HOLD_TMO)
   ) u_hold (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .wr_ev        (wr_ev & fdd2_sel),
      .reg_sel      (addr[1:0]),
      .wr_data      (cpu_dout[DRV_BITS-1:0]),
      .fdd_drq      (fdd_drq),
      .fdd_busy     (fdd_busy),
      .cpu_hold     (cpu_hold),
      .hold_timeout (hold_timeout),
      .fdd_side     (fdd_side),
      .fdd_drive    (fdd_drive)
   );

endmodule

// File: doc/specialist_mmu.md
SPECIALIST_MMU -- requirements
Module: specialist_mmu

Interface
REQ-001 Parameter PAGE_BITS, default 4: page register width; pages 0..2^PAGE_BITS-1.
REQ-002 Parameter NDRIVES, default 2: floppy drive count; DRV_BITS = max(1, clog2(NDRIVES)).
REQ-003 Parameter HOLD_TMO, default 65535: clk_sys cycles before a stuck CPU hold is force-released.
REQ-004 Parameter ADDR_W, default 25: RAM address width; SHALL be at least PAGE_BITS+16.
REQ-005 Ports, clock and reset first:
- clk_sys  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high.
- mx, mxd  in  1 each  MX model; disk enabled.
- mon  in  8  monitor ROM bank for non-disk mode.
- rks_load  in  1  tape image loading.
- addr  in  16  CPU address.
- cpu_wr_n  in  1  CPU write strobe, active-low.
- cpu_dout  in  8  CPU write data.
- fdd_drq, fdd_busy  in  1 each  controller status.
- img_mounted  in  1  image-mount pulse.
- img_drive  in  DRV_BITS  drive index of the mount.
- ram_addr  out  ADDR_W  mapped RAM address.
- rom_sel, base_sel, ppi1_sel, ppi2_sel, fdd_sel, pit_sel, pal_sel, page_sel, fdd2_sel  out  1 each  decodes.
- page  out  PAGE_BITS  current page.
- color_mx  out  8  MX palette.
- fdd_side  out  1  head side.
- fdd_drive  out  DRV_BITS  selected drive.
- fdd_ready  out  1  selected drive has a mounted image.
- cpu_hold  out  1  CPU hold request.
- hold_timeout  out  1  sticky flag: the last hold was force-released.

Function
REQ-006 romp SHALL be (page==1).
REQ-007 Decode SHALL be combinational, first match wins, at most one select high:
- MX, mxd, romp, 0000-BFFF: rom.
- MX, not mxd, romp, 0000-0FFF: rom.
- MX, not mxd, C000-CFFF: rom.
- MX, FFC0-FFDF: base.
- MX, FFE0/E4/E8/EC/F0/F8/FC, each a 4-byte window: ppi1/ppi2/fdd/pit/fdd2/pal/page.
- MX, FFF4-FFF7: no select.
- Original, romp, 0000-0FFF: rom.
- Original, C000-CFFF: rom.
- Original, F000-F7FF: ppi2.
- Original, F800-FFFF: ppi1.
- Otherwise: base_sel = romp.
REQ-008 ram_addr:
- mxd=0, rom_sel=1: {mon, addr[11:0]}.
- mxd=0, rom_sel=0: addr zero-extended.
- mxd=1, base_sel=1: addr zero-extended.
- mxd=1, base_sel=0: {page, addr} zero-extended.
REQ-009 A write event SHALL be the registered falling edge of cpu_wr_n, one cycle wide; a held-low strobe SHALL produce exactly one event.
REQ-010 A page write SHALL apply only when mxd=1, decoded by addr[1:0]:
- 0: page=0.
- 1: page = 2 + cpu_dout[PAGE_BITS-1:0], saturating at 2^PAGE_BITS-1.
- 2 or 3: page=1.
REQ-011 page SHALL be cleared to 0 in any cycle where !(mx&mxd) and addr[15]=1; this clear SHALL override a same-cycle page write.
REQ-012 page priority SHALL be: reset (page=1), then rks_load (page=0), then REQ-011, then REQ-010.
REQ-013 A pal write event SHALL load color_mx <= cpu_dout; reset or rks_load SHALL load 8'hF0.
REQ-014 fdd2 write events, decoded by addr[1:0]:
- 0: set cpu_hold and clear hold_timeout.
- 2: fdd_side <= cpu_dout[0].
- 3: fdd_drive <= cpu_dout[DRV_BITS-1:0], clamped to NDRIVES-1.
- 1: ignored.
REQ-015 cpu_hold SHALL clear in any cycle where fdd_drq | ~fdd_busy; the clear SHALL win over a same-cycle set.
REQ-016 The hold counter SHALL zero whenever cpu_hold=0 and increment while it is 1. When the counter reaches HOLD_TMO-1 with no release, the next cycle SHALL clear cpu_hold and set hold_timeout.
REQ-017 A rising edge of img_mounted SHALL set per-drive ready bit [img_drive]. Ready bits SHALL be sticky across reset and SHALL power up at 0.
REQ-018 fdd_ready SHALL equal the ready bit of fdd_drive.

Reset
REQ-019 On reset, registers SHALL take these values:
- page=1
- color_mx=F0
- fdd_side=0
- fdd_drive=0
- cpu_hold=0
- hold_timeout=0
- counter=0
- write-edge history=1
The ready bits of REQ-017 SHALL be unaffected. Decode outputs SHALL follow the inputs combinationally.

Structure
REQ-020 Package specialist_pkg SHALL hold the I/O window base constants (FFC0, FFE0-FFFC), PAGE_ROM=1 and PALETTE_RESET=8'hF0.
REQ-021 The single sub-module fdd_hold_ctrl SHALL contain the hold, timeout counter and side/drive registers; decode and paging SHALL stay in the top.

Verification
REQ-022 mx=1, mxd=1, reset, then write 05 to FFFD -> page=7; write 0F to FFFD with PAGE_BITS=4 -> page=15 (saturated).
REQ-023 mx=1, mxd=0, page=1, read 8000 -> page=0 next cycle; a simultaneous write to FFFE -> page=0.
REQ-024 Write to FFF0 with fdd_busy=1, fdd_drq=0 -> cpu_hold=1; fdd_drq=1 at cycle 10 -> cpu_hold=0 at cycle 11, hold_timeout=0.
REQ-025 HOLD_TMO=16, busy stuck -> cpu_hold falls exactly 16 cycles after set, hold_timeout=1; a new FFF0 write clears hold_timeout.
REQ-026 img_mounted pulse with img_drive=1 -> fdd_ready=0 while fdd_drive=0; write 01 to FFF3 -> fdd_ready=1; reset -> fdd_ready=0 (drive 0), drive-1 bit retained.
REQ-027 mx=0, mxd=0, mon=1C, read C123 -> rom_sel=1, ram_addr=1C123; read F801 -> ppi1_sel=1 only.
